// File: rtl/ahb_sub_mem.sv
// ahb_sub_mem: memory-backed AHB subordinate with programmable wait states, byte strobes and two-cycle ERROR responses
// ports: hclk/hreset clock and async reset; hsel/haddr/htrans/hwrite/hsize/hready address phase;
//        hwdata/hwstrb write data phase; wait_cfg waits per OKAY transfer; hrdata/hreadyout/hresp response
module ahb_sub_mem #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 256,
  parameter int WAIT_WIDTH = 4
) (
  input  logic                    hclk,
  input  logic                    hreset,
  input  logic                    hsel,
  input  logic [ADDR_WIDTH-1:0]   haddr,
  input  logic [1:0]              htrans,
  input  logic                    hwrite,
  input  logic [2:0]              hsize,
  input  logic [DATA_WIDTH-1:0]   hwdata,
  input  logic [DATA_WIDTH/8-1:0] hwstrb,
  input  logic                    hready,
  input  logic [WAIT_WIDTH-1:0]   wait_cfg,
  output logic [DATA_WIDTH-1:0]   hrdata,
  output logic                    hreadyout,
  output logic                    hresp
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int IW = MEM_DEPTH > 1 ? $clog2(MEM_DEPTH) : 1;
  localparam logic [63:0] MEM_BYTES = 64'(MEM_DEPTH) * 64'(NB);
  typedef enum logic [2:0] {IDLE, WAIT, LAST, ERR1, ERR2} state_t;
  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic                   write_q, write_d;
  logic [2:0]             size_q, size_d;
  logic [WAIT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                   accept, err, commit;
  logic [IW-1:0]          word;
  logic [NB-1:0]          lane_we;
  logic [DATA_WIDTH-1:0]  mem [MEM_DEPTH];
  int                     lo;
  // new address phases are only taken while this subordinate is ready
  assign accept = hsel && hready && htrans[1] && (state_q == IDLE || state_q == LAST || state_q == ERR2);
  assign err = 64'(haddr) >= MEM_BYTES || hsize > 3'($clog2(NB)) ||
               |(haddr & ((ADDR_WIDTH'(1) << hsize) - ADDR_WIDTH'(1)));
  assign word = IW'(addr_q / ADDR_WIDTH'(NB));
  assign lo = int'(addr_q % ADDR_WIDTH'(NB));
  // the reset guard discards a write pending when hreset rises
  assign commit = state_q == LAST && write_q && !hreset;
  assign hreadyout = state_q == IDLE || state_q == LAST || state_q == ERR2;
  assign hresp = state_q == ERR1 || state_q == ERR2;
  assign hrdata = (state_q == WAIT || state_q == LAST) ? mem[word] : '0;
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    write_d = write_q;
    size_d = size_q;
    cnt_d = cnt_q;
    if (accept) begin
      addr_d = haddr;
      write_d = hwrite;
      size_d = hsize;
      cnt_d = wait_cfg;
      state_d = err ? ERR1 : wait_cfg != '0 ? WAIT : LAST;
    end else if (state_q == WAIT) begin
      cnt_d = cnt_q - WAIT_WIDTH'(1);
      state_d = cnt_q == WAIT_WIDTH'(1) ? LAST : WAIT;
    end else begin
      state_d = state_q == ERR1 ? ERR2 : IDLE;
    end
  end
  always_comb begin
    lane_we = '0;
    for (int i = 0; i < NB; i++) lane_we[i] = hwstrb[i] && i >= lo && i < lo + (1 << size_q);
  end
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q <= IDLE;
      addr_q <= '0;
      write_q <= 1'b0;
      size_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      write_q <= write_d;
      size_q <= size_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge hclk) begin
    if (commit)
      for (int i = 0; i < NB; i++)
        if (lane_we[i]) mem[word][i*8 +: 8] <= hwdata[i*8 +: 8];
  end
endmodule

// File: tb/tb_ahb_sub_mem.sv
// tb_ahb_sub_mem: randomized and directed checks of ahb_sub_mem against a byte-array reference model
module tb_ahb_sub_mem;
  logic        hclk = 1'b0, hreset = 1'b1, hsel = 1'b0, hwrite = 1'b0;
  logic [31:0] haddr = '0, hwdata = '0, hrdata;
  logic [1:0]  htrans = '0;
  logic [2:0]  hsize = '0;
  logic [3:0]  hwstrb = '0, wait_cfg = '0;
  logic        hready, hreadyout, hresp;
  int          total = 0, bad = 0;
  logic [7:0]  ref_mem [1024];
  assign hready = hreadyout;
  always #5 hclk = ~hclk;
  ahb_sub_mem dut (
    .hclk(hclk), .hreset(hreset), .hsel(hsel), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hwstrb(hwstrb), .hready(hready),
    .wait_cfg(wait_cfg), .hrdata(hrdata), .hreadyout(hreadyout), .hresp(hresp)
  );
  task automatic step;
    @(posedge hclk);
    #1;
  endtask
  function automatic bit m_err(input logic [31:0] a, input logic [2:0] sz);
    return a >= 32'd1024 || sz > 3'd2 || (a % (32'd1 << sz)) != 0;
  endfunction
  function automatic logic [31:0] m_word(input logic [31:0] a);
    int b = int'(a) / 4 * 4;
    return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
  endfunction
  task automatic m_write(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d, input logic [3:0] s);
    for (int k = 0; k < (1 << sz); k++) begin
      int b = int'(a) + k;
      if (s[b % 4]) ref_mem[b] = d[(b % 4) * 8 +: 8];
    end
  endtask
  task automatic do_xfer(input string nm, input logic [31:0] a, input logic w, input logic [2:0] sz,
                         input logic [31:0] d, input logic [3:0] s, input int wc);
    bit e = m_err(a, sz);
    hsel = 1'b1; htrans = 2'b10; haddr = a; hwrite = w; hsize = sz; wait_cfg = 4'(wc);
    step;
    hsel = 1'b0; htrans = 2'b00; haddr = $urandom; hwrite = 1'($urandom); hsize = 3'($urandom);
    wait_cfg = 4'($urandom); hwdata = d; hwstrb = s;
    if (e) begin
      total++;
      if (hreadyout !== 1'b0 || hresp !== 1'b1) begin
        bad++;
        $display("FAIL %s err1 addr=%h got ready=%b resp=%b want 0/1", nm, a, hreadyout, hresp);
      end
      hsel = 1'b1; htrans = 2'b11; haddr = 32'hffff_fff0;
      step;
      hsel = 1'b0; htrans = 2'b00;
      total++;
      if (hreadyout !== 1'b1 || hresp !== 1'b1 || hrdata !== 32'h0) begin
        bad++;
        $display("FAIL %s err2 addr=%h got ready=%b resp=%b rdata=%h want 1/1/0", nm, a, hreadyout, hresp, hrdata);
      end
      step;
    end else begin
      for (int n = 0; n < wc; n++) begin
        total++;
        if (hreadyout !== 1'b0 || hresp !== 1'b0) begin
          bad++;
          $display("FAIL %s wait%0d addr=%h got ready=%b resp=%b want 0/0", nm, n, a, hreadyout, hresp);
        end
        hsel = 1'b1; htrans = 2'b10; haddr = 32'hffff_fff0;
        step;
        hsel = 1'b0; htrans = 2'b00;
      end
      total++;
      if (hreadyout !== 1'b1 || hresp !== 1'b0 || (!w && hrdata !== m_word(a))) begin
        bad++;
        $display("FAIL %s last addr=%h got ready=%b resp=%b rdata=%h want 1/0 rdata=%h",
                 nm, a, hreadyout, hresp, hrdata, w ? hrdata : m_word(a));
      end
      if (w) m_write(a, sz, d, s);
      step;
    end
  endtask
  task automatic test_reset;
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h10; hwrite = 1'b1;
    step;
    step;
    total++;
    if (hreadyout !== 1'b1 || hresp !== 1'b0 || hrdata !== 32'h0) begin
      bad++;
      $display("FAIL reset got ready=%b resp=%b rdata=%h want 1/0/0", hreadyout, hresp, hrdata);
    end
    hsel = 1'b0; htrans = 2'b00; hreset = 1'b0;
    step;
  endtask
  task automatic test_fill;
    for (int i = 0; i < 256; i++) do_xfer("fill", 32'(i * 4), 1'b1, 3'd2, $urandom, 4'hf, 0);
  endtask
  task automatic test_back_to_back;
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h10; hwrite = 1'b1; hsize = 3'd2; wait_cfg = 4'd0;
    step;
    total++;
    if (hreadyout !== 1'b1 || hresp !== 1'b0) begin
      bad++;
      $display("FAIL b2b write got ready=%b resp=%b want 1/0", hreadyout, hresp);
    end
    hwdata = 32'hdeadbeef; hwstrb = 4'hf; haddr = 32'h10; hwrite = 1'b0;
    step;
    hsel = 1'b0; htrans = 2'b00;
    total++;
    if (hreadyout !== 1'b1 || hresp !== 1'b0 || hrdata !== 32'hdeadbeef) begin
      bad++;
      $display("FAIL b2b read got ready=%b resp=%b rdata=%h want 1/0/deadbeef", hreadyout, hresp, hrdata);
    end
    m_write(32'h10, 3'd2, 32'hdeadbeef, 4'hf);
    step;
  endtask
  task automatic test_wait2;
    do_xfer("wait2 read", 32'h10, 1'b0, 3'd2, 32'h0, 4'h0, 2);
  endtask
  task automatic test_byte;
    do_xfer("byte write", 32'h11, 1'b1, 3'd0, 32'h0000aa00, 4'h2, 1);
    do_xfer("byte read", 32'h10, 1'b0, 3'd2, 32'h0, 4'h0, 0);
    total++;
    if (m_word(32'h10) !== 32'hdeadaaef) begin
      bad++;
      $display("FAIL byte model got %h want deadaaef", m_word(32'h10));
    end
    do_xfer("nostrb write", 32'h12, 1'b1, 3'd0, 32'h00550000, 4'h0, 0);
    do_xfer("nostrb read", 32'h10, 1'b0, 3'd2, 32'h0, 4'h0, 1);
  endtask
  task automatic test_errors;
    do_xfer("oor write", 32'd1024, 1'b1, 3'd2, 32'h12345678, 4'hf, 3);
    do_xfer("misalign read", 32'h02, 1'b0, 3'd2, 32'h0, 4'h0, 2);
    do_xfer("oversize write", 32'h10, 1'b1, 3'd3, 32'h0, 4'hf, 0);
    do_xfer("post err read0", 32'h0, 1'b0, 3'd2, 32'h0, 4'h0, 0);
    do_xfer("post err read10", 32'h10, 1'b0, 3'd2, 32'h0, 4'h0, 0);
  endtask
  task automatic test_idle_busy;
    hwdata = 32'h0; hwstrb = 4'hf; hwrite = 1'b1; haddr = 32'h10; hsize = 3'd2; wait_cfg = 4'd2;
    for (int k = 0; k < 3; k++) begin
      hsel = k != 2; htrans = k == 0 ? 2'b00 : k == 1 ? 2'b01 : 2'b10;
      step;
      total++;
      if (hreadyout !== 1'b1 || hresp !== 1'b0) begin
        bad++;
        $display("FAIL idle/busy/unsel case%0d got ready=%b resp=%b want 1/0", k, hreadyout, hresp);
      end
    end
    hsel = 1'b0; htrans = 2'b00;
    step;
    do_xfer("idle check read", 32'h10, 1'b0, 3'd2, 32'h0, 4'h0, 0);
  endtask
  task automatic test_reset_mid_wait;
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h20; hwrite = 1'b1; hsize = 3'd2; wait_cfg = 4'd3;
    step;
    hsel = 1'b0; htrans = 2'b00; hwdata = ~m_word(32'h20); hwstrb = 4'hf;
    step;
    total++;
    if (hreadyout !== 1'b0) begin
      bad++;
      $display("FAIL midwait pre got ready=%b want 0", hreadyout);
    end
    #2 hreset = 1'b1;
    #1;
    total++;
    if (hreadyout !== 1'b1 || hresp !== 1'b0 || hrdata !== 32'h0) begin
      bad++;
      $display("FAIL midwait reset got ready=%b resp=%b rdata=%h want 1/0/0", hreadyout, hresp, hrdata);
    end
    step;
    hreset = 1'b0;
    step;
    do_xfer("midwait old", 32'h20, 1'b0, 3'd2, 32'h0, 4'h0, 1);
  endtask
  task automatic test_random;
    for (int t = 0; t < 200; t++) begin
      logic [31:0] a;
      logic [2:0] sz;
      int sel;
      sel = $urandom_range(0, 9);
      sz = 3'($urandom_range(0, 2));
      a = 32'($urandom_range(0, 1023));
      a = a & ~((32'd1 << sz) - 32'd1);
      if (sel == 0) a = 32'd1024 + 32'($urandom_range(0, 3000));
      if (sel == 1) sz = 3'd3 + 3'($urandom_range(0, 4));
      if (sel == 2) begin
        sz = 3'($urandom_range(1, 2));
        a = a | 32'd1;
      end
      do_xfer("rand", a, 1'($urandom), sz, $urandom, 4'($urandom), $urandom_range(0, 3));
    end
    for (int i = 0; i < 16; i++) do_xfer("rand sweep", 32'($urandom_range(0, 255) * 4), 1'b0, 3'd2, 32'h0, 4'h0, 0);
  endtask
  initial begin
    test_reset;
    test_fill;
    test_back_to_back;
    test_wait2;
    test_byte;
    test_errors;
    test_idle_busy;
    test_reset_mid_wait;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
